// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment BCD display: digit glyphs, dash/blank, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package seven_seg_pkg;

  // Active-low glyphs, bit6 (middle) down to bit0 (top).
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1011000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } state_t;

endpackage

// File: rtl/seven_seg_digit_enc.sv
// One BCD digit to an active-low seven-segment glyph, with optional blanking.
// Latency: combinational.
// Backpressure: none; codes 10..15 render as a dash.
module seven_seg_digit_enc
  import seven_seg_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Blank wins over the digit value; otherwise a straight glyph lookup.
  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seven_seg_bcd_display.sv
// Binary to DIGITS seven-segment digits via sequential double-dabble; dashes on overflow.
// Latency: o_seven/o_done WIDTH+1 cycles after the transfer edge; one value per WIDTH+2 cycles.
// Backpressure: o_ready high only in IDLE; i_valid while busy is dropped. Define SEVEN_SEG_LZB_EN for leading-zero blanking.
module seven_seg_bcd_display
  import seven_seg_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [WIDTH-1:0]      i_bin,
  output logic                  o_ready,
  output logic [7*DIGITS-1:0]   o_seven,
  output logic                  o_done,
  output logic                  o_ovf
);

  localparam int BCDW = 4 * DIGITS;
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] LAST_SHIFT = CNTW'(WIDTH - 1);

  // Display contents right after reset: a single 0 in the ones digit when
  // blanking is compiled in, otherwise zeros in every position.
  function automatic logic [7*DIGITS-1:0] reset_pattern();
    logic [7*DIGITS-1:0] p;
    p = '0;
    for (int k = 0; k < DIGITS; k++) begin
`ifdef SEVEN_SEG_LZB_EN
      p[7*k +: 7] = (k == 0) ? SEG_0 : SEG_BLANK;
`else
      p[7*k +: 7] = SEG_0;
`endif
    end
    return p;
  endfunction

  localparam logic [7*DIGITS-1:0] RESET_SEVEN = reset_pattern();

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     bin_q;
  logic [BCDW-1:0]      bcd_q;
  logic [BCDW-1:0]      bcd_adj;
  logic [CNTW-1:0]      shift_cnt;
  logic                 ovf_flag;
  logic                 transfer;
  logic                 last_shift;
  logic [DIGITS-1:0]    blank;
  logic [7*DIGITS-1:0]  enc_seven;

  assign o_ready    = (state == ST_IDLE);
  assign transfer   = i_valid && o_ready;
  assign last_shift = (shift_cnt == LAST_SHIFT);

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next state: accept in IDLE, WIDTH shift cycles, one LOAD cycle, back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (transfer)   state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_shift) state_nxt = ST_LOAD;
      ST_LOAD:                  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  // Add-3 correction for every BCD digit of 5 or more ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Conversion datapath: capture on transfer, then shift {BCD, binary} left once per cycle.
  // A 1 leaving the top digit means the value does not fit in DIGITS decimals.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bin_q     <= '0;
      bcd_q     <= '0;
      shift_cnt <= '0;
      ovf_flag  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (transfer) begin
            bin_q     <= i_bin;
            bcd_q     <= '0;
            shift_cnt <= '0;
            ovf_flag  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          bcd_q     <= {bcd_adj[BCDW-2:0], bin_q[WIDTH-1]};
          bin_q     <= {bin_q[WIDTH-2:0], 1'b0};
          shift_cnt <= shift_cnt + 1'b1;
          if (bcd_adj[BCDW-1]) ovf_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Leading-zero run: a digit is blanked when it and every digit above it are zero.
  always_comb begin
`ifdef SEVEN_SEG_LZB_EN
    logic zero_run;
    zero_run = 1'b1;
    blank    = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run && (bcd_q[4*k +: 4] == 4'd0);
      blank[k] = zero_run;
    end
`else
    blank = '0;
`endif
  end

  // One glyph encoder per digit.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seven_seg_digit_enc u_enc (
      .digit (bcd_q[4*g +: 4]),
      .blank (blank[g]),
      .seg   (enc_seven[7*g +: 7])
    );
  end

  // Output registers: updated only in LOAD and held otherwise; o_done marks the update.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_seven <= RESET_SEVEN;
      o_ovf   <= 1'b0;
      o_done  <= 1'b0;
    end else begin
      o_done <= (state == ST_LOAD);
      if (state == ST_LOAD) begin
        o_ovf   <= ovf_flag;
        o_seven <= ovf_flag ? {DIGITS{SEG_DASH}} : enc_seven;
      end
    end
  end

endmodule

// File: doc/seven_seg_bcd_display.md
SEVEN_SEG_BCD_DISPLAY -- requirements
Module: seven_seg_bcd_display

Interface
REQ-001 SHALL have parameter WIDTH, default 16, binary input width (4..32).
REQ-002 SHALL have parameter DIGITS, default 5, number of decimal seven-segment digits driven (1..10).
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_valid  input  1  request to convert i_bin.
REQ-006 i_bin  input  WIDTH  unsigned binary value to display.
REQ-007 o_ready  output  1  high when a new value can be accepted.
REQ-008 o_seven  output  7*DIGITS  segment patterns; digit k (k=0 ones) at bits [7k+6:7k]; active-low; bit0 top, 1 upper-right, 2 lower-right, 3 bottom, 4 lower-left, 5 upper-left, 6 middle.
REQ-009 o_done  output  1  one-cycle pulse in the cycle o_seven updates.
REQ-010 o_ovf  output  1  value of the last completed conversion exceeded 10^DIGITS-1.

Function
REQ-011 Transfer SHALL occur on a rising edge where i_valid=1 and o_ready=1; i_bin is captured; i_valid while o_ready=0 SHALL be ignored (no queueing).
REQ-012 FSM states IDLE, SHIFT, LOAD; IDLE->SHIFT on transfer; SHIFT->LOAD after exactly WIDTH shift cycles; LOAD->IDLE unconditionally.
REQ-013 o_ready SHALL be 1 only in IDLE.
REQ-014 SHIFT SHALL implement sequential double-dabble: each cycle, every BCD digit >=5 gets +3, then the {BCD, binary} register shifts left one bit.
REQ-015 A 1 shifted out of the top BCD digit during SHIFT SHALL set an internal overflow flag, cleared on each transfer.
REQ-016 In LOAD, o_seven SHALL be written from the BCD digits (0..9 as standard patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1011000, 8=0000000, 9=0010000), o_ovf SHALL take the overflow flag, and o_done SHALL pulse.
REQ-017 On overflow all digits SHALL show dash 0111111.
REQ-018 Latency: o_seven/o_done valid WIDTH+1 cycles after the transfer edge; throughput one value per WIDTH+2 cycles.
REQ-019 o_seven and o_ovf SHALL hold between LOAD cycles.

Reset
REQ-020 i_rst=1 SHALL, at the next edge, force IDLE, o_ready=1, o_done=0, o_ovf=0, every digit pattern 1000000 (subject to REQ-023), clearing internal registers.
REQ-021 Reset during SHIFT or LOAD SHALL abort the conversion with no o_done pulse; reset SHALL dominate a simultaneous transfer.

Configuration
REQ-022 Leading-zero blanking compiled in by macro SEVEN_SEG_LZB_EN.
REQ-023 With SEVEN_SEG_LZB_EN defined: every zero digit above the most significant non-zero digit SHALL show 1111111; digit 0 never blanked; dash display under overflow unaffected; reset shows blank upper digits and 0 in digit 0.
REQ-024 Without SEVEN_SEG_LZB_EN: all digits always shown, including leading zeros.

Structure
REQ-025 Package seven_seg_pkg SHALL hold the 7-bit digit pattern constants, dash and blank constants, and the FSM state type.
REQ-026 One sub-module seven_seg_digit_enc (4-bit digit, blank flag -> 7-bit pattern, combinational) SHALL be instantiated DIGITS times.

Verification
REQ-027 WIDTH=16, DIGITS=5, i_bin=0 -> after 17 cycles o_seven = five x 1000000, o_ovf=0, o_done pulse.
REQ-028 WIDTH=16, DIGITS=5, i_bin=65535 -> digits (4..0) 6,5,5,3,5 patterns, o_ovf=0, o_done exactly at transfer+17.
REQ-029 WIDTH=16, DIGITS=4, i_bin=10000 -> all four digits 0111111, o_ovf=1; next i_bin=9999 -> 9,9,9,9, o_ovf=0.
REQ-030 i_valid held high with values 12 then 34 -> second transfer exactly 18 cycles after first; inputs presented while o_ready=0 have no effect.
REQ-031 i_rst asserted at SHIFT cycle 5 -> no o_done, o_ready=1 next cycle, o_seven reset pattern.
REQ-032 SEVEN_SEG_LZB_EN defined, DIGITS=5, i_bin=42 -> digits 4..2 = 1111111, digit1 = 0011001, digit0 = 0100100; i_bin=0 -> only digit0 shows 1000000.
